// File: rtl/cache_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : cache_port_arbiter_if
// Brief    : Single-beat cache access port (request fields plus ready/data)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cache_port_arbiter_if;
  logic [31:0] mem_a;
  logic        mem_access;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;
  logic [31:0] mem_st_data;
  logic        mem_ready;
  logic [31:0] mem_data;

  // Master issues the access; slave completes it.
  modport master (
    output mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data,
    input  mem_ready, mem_data
  );

  modport slave (
    input  mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data,
    output mem_ready, mem_data
  );
endinterface

`default_nettype wire

// File: rtl/cache_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : cache_port_arbiter
// Brief    : Arbitrates inst/data cache ports onto one registered bridge port
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_port_arbiter #(
  parameter int unsigned FIXED_DPRIO = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  cache_port_arbiter_if.slave         inst_port,
  cache_port_arbiter_if.slave         data_port,
  cache_port_arbiter_if.master        mem_port,
  output logic [1:0]                  grant
);

  localparam logic c_dprio = (FIXED_DPRIO != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_d;

  logic [31:0] r_a;
  logic        r_access;
  logic        r_write;
  logic [1:0]  r_size;
  logic [3:0]  r_sel;
  logic [31:0] r_st_data;

  logic        w_pick_i;
  logic        w_pick_d;
  logic        w_capture;
  logic        w_done;
  logic        w_i_ready;
  logic        w_d_ready;

  logic [31:0] w_cap_a;
  logic        w_cap_write;
  logic [1:0]  w_cap_size;
  logic [3:0]  w_cap_sel;
  logic [31:0] w_cap_st_data;

  // Inst wins when alone, or on a round-robin tie after a data grant.
  assign w_pick_i = inst_port.mem_access &&
                    (!data_port.mem_access || (!c_dprio && r_last_d));
  assign w_pick_d = data_port.mem_access && !w_pick_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_done       = 1'b0;
    w_i_ready    = 1'b0;
    w_d_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_i) begin
          w_next_state = OWN_I;
          w_capture    = 1'b1;
        end else if (w_pick_d) begin
          w_next_state = OWN_D;
          w_capture    = 1'b1;
        end
      end
      OWN_I: begin
        if (mem_port.mem_ready) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
          w_i_ready    = 1'b1;
        end
      end
      OWN_D: begin
        if (mem_port.mem_ready) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
          w_d_ready    = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    if (w_pick_i) begin
      w_cap_a       = inst_port.mem_a;
      w_cap_write   = inst_port.mem_write;
      w_cap_size    = inst_port.mem_size;
      w_cap_sel     = inst_port.mem_sel;
      w_cap_st_data = inst_port.mem_st_data;
    end else begin
      w_cap_a       = data_port.mem_a;
      w_cap_write   = data_port.mem_write;
      w_cap_size    = data_port.mem_size;
      w_cap_sel     = data_port.mem_sel;
      w_cap_st_data = data_port.mem_st_data;
    end
  end

  // Request fields stay frozen for the whole ownership; only access drops on completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a       <= 32'h0;
      r_access  <= 1'b0;
      r_write   <= 1'b0;
      r_size    <= 2'b00;
      r_sel     <= 4'h0;
      r_st_data <= 32'h0;
      r_last_d  <= 1'b1;
    end else if (w_capture) begin
      r_a       <= w_cap_a;
      r_access  <= 1'b1;
      r_write   <= w_cap_write;
      r_size    <= w_cap_size;
      r_sel     <= w_cap_sel;
      r_st_data <= w_cap_st_data;
      r_last_d  <= w_pick_d;
    end else if (w_done) begin
      r_access  <= 1'b0;
    end
  end

  assign mem_port.mem_a       = r_a;
  assign mem_port.mem_access  = r_access;
  assign mem_port.mem_write   = r_write;
  assign mem_port.mem_size    = r_size;
  assign mem_port.mem_sel     = r_sel;
  assign mem_port.mem_st_data = r_st_data;

  assign inst_port.mem_ready  = w_i_ready;
  assign inst_port.mem_data   = mem_port.mem_data;
  assign data_port.mem_ready  = w_d_ready;
  assign data_port.mem_data   = mem_port.mem_data;

  assign grant = r_state;

endmodule

`default_nettype wire

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Two-requester arbiter: the instruction-cache port and the data-cache port share the single cache-side port of the AXI bridge.
- The bridge takes one request at a time: single beat, fixed IDs.
- The arbiter grants one requester, registers that requester's request onto the shared port, and holds it until `mem_ready`. It then routes `ready` and `data` back to the owner and returns to idle with a 1-cycle bubble, so the bridge never sees a stale access.

Parameters:
- FIXED_DPRIO, 0, 0 = round-robin on ties; 1 = data port always wins ties.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- i_mem_a  in  32  inst requester address
- i_mem_access  in  1  inst request valid; held until i_mem_ready
- i_mem_write  in  1  inst write flag (normally 0)
- i_mem_size  in  2  inst transfer size
- i_mem_sel  in  4  inst byte strobes
- i_mem_st_data  in  32  inst store data
- i_mem_ready  out  1  inst transaction done
- i_mem_data  out  32  inst read data
- d_mem_a / d_mem_access / d_mem_write / d_mem_size / d_mem_sel / d_mem_st_data  in  32/1/1/2/4/32  data requester, same meaning as the inst signals
- d_mem_ready  out  1  data transaction done
- d_mem_data  out  32  data read data
- mem_a  out  32  shared-port address (registered)
- mem_access  out  1  shared-port request (registered)
- mem_write  out  1  registered
- mem_size  out  2  registered
- mem_sel  out  4  registered
- mem_st_data  out  32  registered
- mem_ready  in  1  bridge done (single-cycle pulse)
- mem_data  in  32  bridge read data, valid with mem_ready
- grant  out  2  current owner: 2'b00 none, 2'b01 inst, 2'b10 data

Behaviour:
- Async reset (resetn=0), applied immediately:
  - state=IDLE, last_grant=DATA.
  - All registered shared-port outputs 0; mem_access=0; grant=0.
- Reset mid-transaction abandons it; no ready is forwarded. The bridge has its own reset.
- FSM states: IDLE, OWN_I, OWN_D.
- IDLE, arbitration:
  - Only i_mem_access=1 -> OWN_I.
  - Only d_mem_access=1 -> OWN_D.
  - Both=1:
    - FIXED_DPRIO=1 -> OWN_D.
    - FIXED_DPRIO=0 -> the port not equal to last_grant.
  - Neither -> stay in IDLE.
  - On a grant, the winner's a/write/size/sel/st_data are captured into the shared-port registers and mem_access<=1 at the same edge; last_grant is updated to the winner.
- Latency: request visible in IDLE at cycle N -> mem_access=1 at cycle N+1.
- OWN_x:
  - Shared-port registers hold constant; mem_access stays 1.
  - Requester inputs are ignored, including changes or a dropped access.
- Completion:
  - When mem_ready=1 in OWN_x: x_mem_ready=1 combinationally in that cycle; x_mem_data=mem_data.
  - At that edge: mem_access<=0, state<=IDLE.
  - Minimum gap between consecutive shared-port accesses: 1 cycle with mem_access=0.
- Ready gating: x_mem_ready is never asserted outside OWN_x. mem_ready in IDLE is ignored.
- Data outputs: i_mem_data and d_mem_data both always mirror mem_data; only the ready qualifies them.
- grant reflects the state: IDLE=00, OWN_I=01, OWN_D=10.
- A requester that keeps access=1 after its ready is re-arbitrated in the next IDLE cycle like any new request.
- Round-robin fairness: with both requesters continuously requesting and FIXED_DPRIO=0, grants alternate I, D, I, D. The first tie after reset goes to I.
- No combinational path from requester inputs to shared-port outputs.

Test Plan:
- Single read:
  - Stimulus: d_mem_access=1, d_mem_a=0x8000_1000, write=0, size=2 at cycle 0; bench asserts mem_ready with mem_data=0xDEAD_BEEF at cycle 4.
  - Required: mem_access=1 with mem_a=0x8000_1000 from cycle 1; d_mem_ready=1 and d_mem_data=0xDEAD_BEEF at cycle 4; mem_access=0 at cycle 5; i_mem_ready=0 throughout.
- Tie after reset:
  - Stimulus: both access=1 from cycle 0, FIXED_DPRIO=0; each transaction acked 2 cycles after mem_access rises.
  - Required: grant sequence 01, 00, 10, 00, 01; i_mem_ready and d_mem_ready alternate.
- Fixed priority:
  - Stimulus: FIXED_DPRIO=1, both requesters continuously requesting.
  - Required: every grant is 10; i_mem_ready never asserted while d_mem_access=1.
- Write capture stability:
  - Stimulus: d write with a=0x1FAF_0000, sel=4'b0011, st_data=0x1234_5678; requester changes d_mem_a to 0x0 one cycle after the grant.
  - Required: mem_a, mem_sel and mem_st_data hold the captured values until mem_ready.
- Reset mid-operation:
  - Stimulus: resetn=0 asynchronously while in OWN_I; mem_ready pulses 1 cycle after resetn is released.
  - Required: mem_access=0 and grant=00 immediately on reset; no i_mem_ready pulse.
- Back-to-back turnaround:
  - Stimulus: i requester holds access=1 continuously; mem_ready is returned 1 cycle after each mem_access rise.
  - Required: mem_access pattern 1,1,0,1,1,0,…; exactly one i_mem_ready per high period.
